// File: rtl/reorder_buffer_v2_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_v2_pkg
// Shared types and constants for the reorder buffer and its store/load
// disambiguation scan.
//   ROB_XLEN        : data/address width the entry type is built from
//   ZERO_REG        : architectural register x0, used for cleared entries
//   ROB_ENTRY       : one ROB slot {valid, ready, wr_mem, dest_reg, value,
//                     dest_addr}
//   CDB_DATA        : common data bus payload {valid, value, addr}
//   EMPTY_ROB_ENTRY : value of a free slot
// ---------------------------------------------------------------------------
package reorder_buffer_v2_pkg;

    localparam int ROB_XLEN = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic                wr_mem;
        logic [4:0]          dest_reg;
        logic [ROB_XLEN-1:0] value;
        logic [ROB_XLEN-1:0] dest_addr;
    } ROB_ENTRY;

    typedef struct packed {
        logic                valid;
        logic [ROB_XLEN-1:0] value;
        logic [ROB_XLEN-1:0] addr;
    } CDB_DATA;

    localparam ROB_ENTRY EMPTY_ROB_ENTRY = '{
        valid:     1'b0,
        ready:     1'b0,
        wr_mem:    1'b0,
        dest_reg:  ZERO_REG,
        value:     '0,
        dest_addr: '0
    };

endpackage

// File: rtl/reorder_buffer_v2_store_scan.sv
// ---------------------------------------------------------------------------
// rob_store_scan
// Combinational age-ordered scan deciding whether an issuing load must wait
// for an older store.
//   entries        in  : full ROB entry array
//   head           in  : current head pointer (oldest entry)
//   load_rob_tag   in  : ROB tag of the issuing load
//   load_address   in  : effective address of the issuing load
//   pending_stores out : an older store is unresolved or aliases the load
// ---------------------------------------------------------------------------
module rob_store_scan
    import reorder_buffer_v2_pkg::*;
#(
    parameter int ROB_SIZE = 8,
    parameter int TAG_LEN  = $clog2(ROB_SIZE)
) (
    input  ROB_ENTRY              entries [ROB_SIZE],
    input  logic [TAG_LEN-1:0]    head,
    input  logic [TAG_LEN-1:0]    load_rob_tag,
    input  logic [ROB_XLEN-1:0]   load_address,
    output logic                  pending_stores
);

    logic [TAG_LEN-1:0] load_age;
    logic [TAG_LEN-1:0] entry_age;

    // Ages are distances from head modulo ROB_SIZE; the natural wrap of the
    // TAG_LEN-bit subtraction performs the modulo.
    always_comb begin
        pending_stores = 1'b0;
        entry_age      = '0;
        load_age       = load_rob_tag - head;
        for (int e = 0; e < ROB_SIZE; e++) begin
            entry_age = TAG_LEN'(e) - head;
            if (entries[e].valid && entries[e].wr_mem && (entry_age < load_age) &&
                (!entries[e].ready || (entries[e].dest_addr == load_address))) begin
                pending_stores = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_v2.sv
// ---------------------------------------------------------------------------
// reorder_buffer_v2
// Reorder buffer: in-order allocation at dispatch, out-of-order completion
// from the CDB, in-order commit under a retire handshake, flush on
// mispredict, operand read ports with CDB bypass and a store/load check.
//   clock, reset            : clock, synchronous active-high reset
//   flush                   : squash every entry on the next edge
//   alloc_*                 : dispatch request and new entry fields
//   cdb_*                   : completion broadcast (tag, value, store addr)
//   read_rob_tag/value/ready: NUM_READ packed operand lookup ports
//   load_*, pending_stores  : issuing load and its must-stall result
//   commit_enable, head_*   : retire handshake and head entry contents
//   full, empty, count      : occupancy
//   alloc_slot              : tag the next allocation receives (tail)
// XLEN must equal the package ROB_XLEN that the entry type is built from.
// ---------------------------------------------------------------------------
module reorder_buffer_v2
    import reorder_buffer_v2_pkg::*;
#(
    parameter int ROB_SIZE = 8,
    parameter int NUM_READ = 2,
    parameter int XLEN     = ROB_XLEN,
    localparam int TAG_LEN = $clog2(ROB_SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc_enable,
    input  logic                         alloc_wr_mem,
    input  logic [4:0]                   alloc_dest_reg,
    input  logic                         cdb_valid,
    input  logic [TAG_LEN-1:0]           cdb_rob_tag,
    input  logic [XLEN-1:0]              cdb_value,
    input  logic [XLEN-1:0]              cdb_addr,
    input  logic [NUM_READ*TAG_LEN-1:0]  read_rob_tag,
    output logic [NUM_READ*XLEN-1:0]     read_value,
    output logic [NUM_READ-1:0]          read_ready,
    input  logic [XLEN-1:0]              load_address,
    input  logic [TAG_LEN-1:0]           load_rob_tag,
    output logic                         pending_stores,
    input  logic                         commit_enable,
    output logic                         head_valid,
    output logic [TAG_LEN-1:0]           head_tag,
    output logic                         head_wr_mem,
    output logic [4:0]                   head_dest_reg,
    output logic [XLEN-1:0]              head_value,
    output logic [XLEN-1:0]              head_dest_addr,
    output logic                         full,
    output logic                         empty,
    output logic [TAG_LEN:0]             count,
    output logic [TAG_LEN-1:0]           alloc_slot
);

    ROB_ENTRY           entries [ROB_SIZE];
    logic [TAG_LEN-1:0] head;
    logic [TAG_LEN-1:0] tail;
    CDB_DATA            cdb;
    logic               do_alloc;
    logic               do_commit;

    assign cdb = '{valid: cdb_valid, value: cdb_value, addr: cdb_addr};

    assign full      = (count == (TAG_LEN+1)'(ROB_SIZE));
    assign empty     = (count == '0);
    assign do_alloc  = alloc_enable && !full;
    assign do_commit = commit_enable && head_valid;

    // Statement order matters: the commit clear is written after the CDB
    // update so that a broadcast to the committing head loses. Alloc and
    // commit can only share an index when full (alloc blocked) or empty
    // (commit blocked).
    // NOTE: the entry array is reset explicitly because flush must squash
    // every valid bit, and reset and flush share the same path.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= EMPTY_ROB_ENTRY;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cdb.valid && entries[cdb_rob_tag].valid) begin
                entries[cdb_rob_tag].value <= cdb.value;
                entries[cdb_rob_tag].ready <= 1'b1;
                if (entries[cdb_rob_tag].wr_mem) begin
                    entries[cdb_rob_tag].dest_addr <= cdb.addr;
                end
            end
            if (do_alloc) begin
                entries[tail] <= '{
                    valid:     1'b1,
                    ready:     1'b0,
                    wr_mem:    alloc_wr_mem,
                    dest_reg:  alloc_dest_reg,
                    value:     '0,
                    dest_addr: '0
                };
                tail <= tail + 1'b1;
            end
            if (do_commit) begin
                entries[head] <= EMPTY_ROB_ENTRY;
                head          <= head + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_tag       = head;
    assign alloc_slot     = tail;
    assign head_valid     = entries[head].valid && entries[head].ready;
    assign head_wr_mem    = entries[head].wr_mem;
    assign head_dest_reg  = entries[head].dest_reg;
    assign head_value     = entries[head].value;
    assign head_dest_addr = entries[head].dest_addr;

    // Operand read ports; a same-cycle CDB broadcast to the looked-up tag
    // is forwarded so the consumer does not wait an extra cycle.
    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [TAG_LEN-1:0] tag;
        logic               bypass;

        assign tag    = read_rob_tag[i*TAG_LEN +: TAG_LEN];
        assign bypass = cdb_valid && (cdb_rob_tag == tag);

        assign read_value[i*XLEN +: XLEN] = bypass ? cdb_value : entries[tag].value;
        assign read_ready[i]              = bypass || (entries[tag].valid && entries[tag].ready);
    end

    rob_store_scan #(
        .ROB_SIZE (ROB_SIZE),
        .TAG_LEN  (TAG_LEN)
    ) u_store_scan (
        .entries        (entries),
        .head           (head),
        .load_rob_tag   (load_rob_tag),
        .load_address   (load_address),
        .pending_stores (pending_stores)
    );

endmodule

// File: doc/reorder_buffer_v2.md
Name: reorder_buffer_v2

Overview:
Parametrised reorder buffer for the out-of-order core: in-order allocation at dispatch, out-of-order completion from the CDB, in-order commit under a retire-stage handshake.
Generalises the original ROB in four ways:
- configurable depth
- multiple operand read ports with CDB bypass
- an explicit occupancy counter
- a full-pipeline flush for mispredict recovery, plus an age-ordered store/load disambiguation check.

Parameters:
ROB_SIZE, 8, number of entries; power of two, minimum 2.
TAG_LEN, $clog2(ROB_SIZE), tag width (derived, not overridden).
NUM_READ, 2, number of operand read ports.
XLEN, 32, data and address width.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash all entries (mispredict)
alloc_enable  in  1  allocate entry at tail
alloc_wr_mem  in  1  new instruction is a store
alloc_dest_reg  in  5  destination architectural register
cdb_valid  in  1  CDB broadcast valid
cdb_rob_tag  in  TAG_LEN  completing entry
cdb_value  in  XLEN  result value, or store data for stores
cdb_addr  in  XLEN  effective address (stores only)
read_rob_tag  in  NUM_READ*TAG_LEN  operand lookup tags, packed
read_value  out  NUM_READ*XLEN  looked-up values
read_ready  out  NUM_READ  looked-up value is available
load_address  in  XLEN  address of issuing load
load_rob_tag  in  TAG_LEN  tag of issuing load
pending_stores  out  1  load must stall
commit_enable  in  1  retire stage accepts head this cycle
head_valid  out  1  head entry occupied and ready to commit
head_tag  out  TAG_LEN  head pointer
head_wr_mem  out  1  head is a store
head_dest_reg  out  5  head destination register
head_value  out  XLEN  head value / store data
head_dest_addr  out  XLEN  head store address
full  out  1  count == ROB_SIZE
empty  out  1  count == 0
count  out  TAG_LEN+1  occupied entries
alloc_slot  out  TAG_LEN  tag the next allocation receives (= tail)

Behaviour:
- State: entry array {valid, ready, wr_mem, dest_reg, value, dest_addr}; head, tail (TAG_LEN bits, natural wrap); count (TAG_LEN+1 bits).
- Reset (synchronous): all entries cleared, head=tail=count=0.
  - Outputs after reset: empty=1, full=0, head_valid=0, alloc_slot=0, pending_stores=0, read_ready=0.
- Flush: same effect as reset, applied the following edge. Has priority over alloc, CDB and commit in the same cycle.
- Allocation (alloc = alloc_enable && !full):
  - writes {valid=1, ready=0, alloc_wr_mem, alloc_dest_reg, 0, 0} at tail; tail++.
  - Allocation while full is ignored with no state change. Dispatch must check full.
- Completion (CDB): if cdb_valid and entry[cdb_rob_tag].valid, then value<=cdb_value and ready<=1.
  - If the entry is a store, dest_addr<=cdb_addr as well.
  - CDB to an invalid entry is ignored.
- Commit (commit = commit_enable && head_valid): clears entry[head]; head++.
  - commit_enable while !head_valid is ignored.
- Count update: count += alloc - commit. Alloc and commit in the same cycle leave count unchanged.
  - When full, commit and alloc_enable in the same cycle: alloc is still rejected, because full is evaluated before the edge.
- Same-cycle write collisions:
  - CDB to the head tag in the cycle it commits: the commit clear wins.
  - Alloc at a tag also targeted by the CDB: cannot occur for valid entries, since tail is only valid when full.
- Head outputs: combinational from entry[head]. head_valid = valid && ready.
- Read ports (combinational), port i:
  - if cdb_valid && cdb_rob_tag == tag_i: read_value = cdb_value, read_ready = 1 (bypass);
  - else: entry fields, with read_ready = valid && ready.
- Store/load check (combinational):
  - age(t) = (t - head) mod ROB_SIZE.
  - pending_stores = OR over entries e with valid && wr_mem && age(e) < age(load_rob_tag) of (!ready || dest_addr == load_address).
  - Entries younger than the load are ignored.

Decomposition:
- Shared package holds:
  - ROB_ENTRY typedef, parametrised via XLEN and including dest_addr;
  - CDB_DATA typedef, extended with addr;
  - EMPTY_ROB_ENTRY constant;
  - ZERO_REG.
- One sub-module: rob_store_scan. Purely combinational age-ordered scan; inputs are the entry array, head, load tag and load address; output is pending_stores.

Test Plan:
- ROB_SIZE=4: allocate 4 → full=1, count=4, alloc_slot=0. 5th alloc → no change. CDB tag0 value 0x11, then commit → head_tag=1, count=3, full=0.
- Wrap-around: 6 alloc/commit cycles, each completed via CDB → tags issued 0,1,2,3,0,1. Committed values arrive in order; empty=1 at end.
- Simultaneous alloc+commit with count=2 → count stays 2, head and tail both advance.
- Bypass: read tag 2 while CDB broadcasts tag 2 = 0xABCD → read_ready=1 and read_value=0xABCD that same cycle.
- Store at tag1 (unresolved), load at tag3 → pending_stores=1.
  - CDB resolves store addr 0x100: load address 0x200 → 0; load address 0x100 → 1.
  - Store at tag3 with load at tag1 → 0.
- Flush with 3 entries valid, plus alloc and CDB asserted in the same cycle → next cycle count=0, empty=1, head_valid=0, alloc_slot=0.
